rf_multiport: RTL and testbench
===============================

// Module: rf_multiport
// PURPOSE
//   Parametrised integer register file: NRD registered read ports, one write port.
//   Hardware clear sequencer wipes the array after reset or on flush request.
//   Optional write-to-read bypass.
//   Sits between decode (operand fetch) and writeback in the core pipeline.
//   Replaces the fixed 32x32, 2-read, state-gated register file.
// PARAMETERS
//   XLEN     32  data width in bits
//   NREGS    32  number of architectural registers (2..256, not necessarily power of 2)
//   NRD      2   number of read ports (1..4)
//   ZERO_REG 1   1: register 0 hardwired to zero (writes dropped, reads return 0)
//   AW       derived = $clog2(NREGS), not overridable
// PORTS
//   clk        in   1         clock, all logic on rising edge
//   rst        in   1         synchronous reset, active-high
//   flush_req  in   1         request full array clear (pulse)
//   init_done  out  1         1 = array cleared and accepting traffic
//   rd_en      in   NRD       per-port read request
//   rd_addr    in   NRD*AW    per-port address, port p at [p*AW +: AW]
//   rd_data    out  NRD*XLEN  per-port read data, port p at [p*XLEN +: XLEN]
//   rd_valid   out  NRD       per-port data-valid, 1 cycle after accepted rd_en
//   wr_en      in   1         write request
//   wr_addr    in   AW        write address
//   wr_data    in   XLEN      write data
// BEHAVIOUR
//   Reset values: init_done=0, rd_valid=0, rd_data=0, FSM=CLEAR, clear counter=0.
//   FSM CLEAR:
//     - writes 0 to entry [counter] each cycle; counter increments.
//     - after entry NREGS-1 is written -> READY; init_done=1 from the next cycle.
//     - CLEAR lasts exactly NREGS cycles.
//     - wr_en ignored; rd_en ignored (rd_valid stays 0); flush_req ignored.
//   FSM READY:
//     - flush_req=1 -> CLEAR, counter=0; init_done=0 the following cycle.
//     - flush_req and wr_en in the same cycle: flush wins, write dropped.
//   rst mid-CLEAR restarts the sequence at entry 0; no partial-clear state survives.
//   Read (READY only), 1-cycle latency:
//     - rd_en[p] at edge N -> rd_data[p] and rd_valid[p]=1 after edge N+1.
//     - rd_en[p]=0 -> rd_valid[p]=0, rd_data[p] holds its last value.
//     - Addr 0 with ZERO_REG=1 returns 0.
//     - Addr >= NREGS returns 0, rd_valid still 1.
//   Write (READY only): commits at the edge where wr_en=1. Dropped (no state change) when:
//     - addr >= NREGS, or
//     - addr=0 with ZERO_REG=1.
//   Ports are independent; all NRD ports may read the same address in the same cycle.
//   No simulation prints or dumps in RTL.
// CONFIGURATION
//   Macro RF_BYPASS_EN:
//     - defined: read and write to the same (writable) address in the same cycle
//       return the new wr_data.
//     - undefined: that read returns the old stored value; the new value is visible
//       from the next read.
//     - Zero-reg, out-of-range and CLEAR-state rules are unchanged either way.
// STRUCTURE
//   Package rf_pkg:
//     - typedef enum {RF_CLEAR, RF_READY} rf_state_t
//     - localparam function rf_aw(nregs)
//   Sub-module rf_read_port:
//     - one registered read port with zero/out-of-range masking and the RF_BYPASS_EN
//       mux.
//     - instantiated NRD times by generate loop.
//   Storage array, write logic and clear FSM live in rf_multiport.
// TESTING
//   1. rst 1 cycle, NREGS=32 -> init_done=0 for 32 cycles, then 1; all 32 reads
//      return 0.
//   2. Write x5=0xDEADBEEF, next cycle read port0 x5 and port1 x5 -> both return
//      0xDEADBEEF, rd_valid=2'b11 one cycle later.
//   3. Write x0=0x1234 with ZERO_REG=1, then read x0 -> 0x00000000.
//   4. Same-cycle wr x7=0xA5A5A5A5 and rd x7 (x7 held 0x1):
//      - bypass build returns 0xA5A5A5A5;
//      - non-bypass build returns 0x1, next read returns 0xA5A5A5A5.
//   5. Fill x1..x31, pulse flush_req together with wr x3=0x77 -> write dropped,
//      init_done low 32 cycles, all reads return 0.
//   6. Assert rst at CLEAR cycle 10 -> sequence restarts; init_done rises exactly
//      NREGS cycles after rst deasserts. Repeat with NREGS=24, NRD=3:
//      read addr 30 -> 0, rd_valid=1.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared state type and address-width helper for the multi-port register file.
package rf_pkg;

    typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;

    function automatic int rf_aw(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port with zero-register/out-of-range masking; RF_BYPASS_EN adds write forwarding.
// Latency: one cycle from en to valid and data.
// Backpressure: none; data holds its last value while en is low.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    parameter int AW       = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wr_commit,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] data,
    output logic            valid
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic            in_range;
    logic            is_zero;
    logic [XLEN-1:0] nxt;

`ifndef RF_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{wr_commit, wr_addr, wr_data};
`endif

    always_comb begin
        in_range = ({1'b0, addr} < NREGS_W);
        is_zero  = (ZERO_REG != 0) && (addr == '0);
        nxt      = mem_data;
`ifdef RF_BYPASS_EN
        // wr_commit already excludes dropped writes, so forwarding cannot leak into x0
        if (wr_commit && (wr_addr == addr)) nxt = wr_data;
`endif
        if (!in_range || is_zero) nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= en;
            if (en) data <= nxt;
        end
    end

endmodule

// File: rtl/rf_multiport.sv
// Register file: NRD registered read ports, one write port, hardware clear after reset/flush; RF_BYPASS_EN forwards same-cycle writes.
// Latency: reads one cycle; writes commit at the issuing edge; clear takes NREGS cycles.
// Backpressure: init_done low during clear, when reads and writes are ignored.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = rf_aw(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_req,
    output logic                init_done,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_valid,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    rf_state_t       state;
    logic [AW-1:0]   clr_cnt;
    logic [XLEN-1:0] mem [NREGS];
    logic            writable;
    logic            wr_ok;
    logic            rd_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RF_CLEAR;
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                RF_CLEAR: begin
                    if (clr_cnt == AW'(NREGS - 1)) begin
                        state     <= RF_READY;
                        clr_cnt   <= '0;
                        init_done <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                RF_READY: begin
                    if (flush_req) begin
                        state     <= RF_CLEAR;
                        clr_cnt   <= '0;
                        init_done <= 1'b0;
                    end
                end
                default: state <= RF_CLEAR;
            endcase
        end
    end

    // Flush outranks a write issued in the same cycle.
    always_comb begin
        writable = ({1'b0, wr_addr} < NREGS_W) && !((ZERO_REG != 0) && (wr_addr == '0));
        wr_ok    = !rst && (state == RF_READY) && !flush_req && wr_en && writable;
        rd_ok    = (state == RF_READY);
    end

    always_ff @(posedge clk) begin
        if (state == RF_CLEAR) mem[clr_cnt] <= '0;
        else if (wr_ok)        mem[wr_addr] <= wr_data;
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [XLEN-1:0] mem_q;
        assign mem_q = mem[rd_addr[p*AW +: AW]];

        rf_read_port #(
            .XLEN     (XLEN),
            .NREGS    (NREGS),
            .ZERO_REG (ZERO_REG),
            .AW       (AW)
        ) u_port (
            .clk       (clk),
            .rst       (rst),
            .en        (rd_en[p] && rd_ok),
            .addr      (rd_addr[p*AW +: AW]),
            .mem_data  (mem_q),
            .wr_commit (wr_ok),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .data      (rd_data[p*XLEN +: XLEN]),
            .valid     (rd_valid[p])
        );
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Scoreboard bench for rf_multiport: default 32x32/2-port instance plus a 24-entry/3-port instance.
// Expectations for same-cycle read/write follow RF_BYPASS_EN when it is defined for the build.
module tb_rf_multiport;

    typedef struct {
        int          port;
        int          due;
        logic [31:0] data;
    } exp_t;

    logic clk;
    int   cyc;
    int   checks;
    int   errors;
    exp_t qa[$];
    exp_t qb[$];

    logic        a_rst, a_flush, a_init, a_wr_en;
    logic [1:0]  a_rd_en, a_rd_valid;
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [4:0]  a_wr_addr;
    logic [31:0] a_wr_data;

    logic        b_rst, b_flush, b_init, b_wr_en;
    logic [2:0]  b_rd_en, b_rd_valid;
    logic [14:0] b_rd_addr;
    logic [95:0] b_rd_data;
    logic [4:0]  b_wr_addr;
    logic [31:0] b_wr_data;

    rf_multiport dut_a (
        .clk       (clk),
        .rst       (a_rst),
        .flush_req (a_flush),
        .init_done (a_init),
        .rd_en     (a_rd_en),
        .rd_addr   (a_rd_addr),
        .rd_data   (a_rd_data),
        .rd_valid  (a_rd_valid),
        .wr_en     (a_wr_en),
        .wr_addr   (a_wr_addr),
        .wr_data   (a_wr_data)
    );

    rf_multiport #(.NREGS(24), .NRD(3)) dut_b (
        .clk       (clk),
        .rst       (b_rst),
        .flush_req (b_flush),
        .init_done (b_init),
        .rd_en     (b_rd_en),
        .rd_addr   (b_rd_addr),
        .rd_data   (b_rd_data),
        .rd_valid  (b_rd_valid),
        .wr_en     (b_wr_en),
        .wr_addr   (b_wr_addr),
        .wr_data   (b_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        a_rd_en = '0; a_wr_en = 1'b0; a_flush = 1'b0;
        b_rd_en = '0; b_wr_en = 1'b0; b_flush = 1'b0;
    endtask

    task automatic a_rd(input int p, input logic [4:0] addr, input logic [31:0] exp);
        a_rd_en[p] = 1'b1;
        a_rd_addr[p*5 +: 5] = addr;
        qa.push_back('{p, cyc + 1, exp});
    endtask

    task automatic b_rd(input int p, input logic [4:0] addr, input logic [31:0] exp);
        b_rd_en[p] = 1'b1;
        b_rd_addr[p*5 +: 5] = addr;
        qb.push_back('{p, cyc + 1, exp});
    endtask

    task automatic a_wr(input logic [4:0] addr, input logic [31:0] data);
        a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data;
    endtask

    task automatic b_wr(input logic [4:0] addr, input logic [31:0] data);
        b_wr_en = 1'b1; b_wr_addr = addr; b_wr_data = data;
    endtask

    task automatic a_clear_window(input string name);
        for (int i = 0; i < 32; i++) begin
            chk(name, {31'b0, a_init}, 32'd0);
            step();
        end
        chk({name, "_rise"}, {31'b0, a_init}, 32'd1);
    endtask

    task automatic b_clear_window(input string name);
        for (int i = 0; i < 24; i++) begin
            chk(name, {31'b0, b_init}, 32'd0);
            step();
        end
        chk({name, "_rise"}, {31'b0, b_init}, 32'd1);
    endtask

    // Monitors: each expected entry is due exactly one cycle after issue.
    always @(negedge clk) begin
        logic [1:0] seen;
        seen = '0;
        for (int i = qa.size() - 1; i >= 0; i--) begin
            if (qa[i].due == cyc) begin
                chk($sformatf("a_valid%0d", qa[i].port), {31'b0, a_rd_valid[qa[i].port]}, 32'd1);
                chk($sformatf("a_data%0d", qa[i].port), a_rd_data[qa[i].port*32 +: 32], qa[i].data);
                seen[qa[i].port] = 1'b1;
                qa.delete(i);
            end
        end
        for (int p = 0; p < 2; p++)
            if (!seen[p]) chk($sformatf("a_idle_valid%0d", p), {31'b0, a_rd_valid[p]}, 32'd0);
    end

    always @(negedge clk) begin
        logic [2:0] seen;
        seen = '0;
        for (int i = qb.size() - 1; i >= 0; i--) begin
            if (qb[i].due == cyc) begin
                chk($sformatf("b_valid%0d", qb[i].port), {31'b0, b_rd_valid[qb[i].port]}, 32'd1);
                chk($sformatf("b_data%0d", qb[i].port), b_rd_data[qb[i].port*32 +: 32], qb[i].data);
                seen[qb[i].port] = 1'b1;
                qb.delete(i);
            end
        end
        for (int p = 0; p < 3; p++)
            if (!seen[p] && !b_rst) chk($sformatf("b_idle_valid%0d", p), {31'b0, b_rd_valid[p]}, 32'd0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0;
        a_rst = 1'b1; a_flush = 1'b0; a_rd_en = '0; a_rd_addr = '0;
        a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
        b_rst = 1'b1; b_flush = 1'b0; b_rd_en = '0; b_rd_addr = '0;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;

        // Reset and initial clear, then every entry reads zero.
        step();
        a_rst = 1'b0;
        chk("a_reset_valid", {30'b0, a_rd_valid}, 32'd0);
        chk("a_reset_data", a_rd_data[31:0], 32'd0);
        a_clear_window("a_init_clear");
        for (int a = 0; a < 16; a++) begin
            a_rd(0, 5'(a), 32'd0);
            a_rd(1, 5'(a + 16), 32'd0);
            step();
        end

        // Write then dual-port read of the same register.
        a_wr(5'd5, 32'hDEADBEEF);
        step();
        a_rd(0, 5'd5, 32'hDEADBEEF);
        a_rd(1, 5'd5, 32'hDEADBEEF);
        step();

        // Register 0 is hardwired.
        a_wr(5'd0, 32'h00001234);
        step();
        a_rd(0, 5'd0, 32'h0);
        step();

        // Same-cycle read and write of x7.
        a_wr(5'd7, 32'h1);
        step();
        a_wr(5'd7, 32'hA5A5A5A5);
`ifdef RF_BYPASS_EN
        a_rd(0, 5'd7, 32'hA5A5A5A5);
`else
        a_rd(0, 5'd7, 32'h1);
`endif
        step();
        a_rd(1, 5'd7, 32'hA5A5A5A5);
        step();

        // Fill, then flush with a colliding write.
        for (int r = 1; r < 32; r++) begin
            a_wr(5'(r), 32'h100 + r);
            step();
        end
        a_rd(0, 5'd31, 32'h11F);
        a_rd(1, 5'd3, 32'h103);
        step();
        a_flush = 1'b1;
        a_wr(5'd3, 32'h77);
        step();
        a_rd_en = 2'b11;
        a_wr(5'd4, 32'h44);
        a_clear_window("a_flush_clear");
        for (int a = 0; a < 16; a++) begin
            a_rd(0, 5'(a), 32'd0);
            a_rd(1, 5'(a + 16), 32'd0);
            step();
        end

        // Reset in the middle of the clear restarts it.
        a_wr(5'd2, 32'h55);
        step();
        a_rst = 1'b1;
        step();
        a_rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        a_rst = 1'b1;
        step();
        a_rst = 1'b0;
        a_clear_window("a_rst_mid_clear");
        a_rd(0, 5'd2, 32'd0);
        a_rd(1, 5'd31, 32'd0);
        step();

        // 24-entry, 3-port instance: out-of-range access.
        step();
        b_rst = 1'b0;
        b_clear_window("b_init_clear");
        b_wr(5'd23, 32'h0000CAFE);
        step();
        b_wr(5'd30, 32'h00000BAD);
        step();
        b_rd(0, 5'd30, 32'd0);
        b_rd(1, 5'd23, 32'h0000CAFE);
        b_rd(2, 5'd24, 32'd0);
        step();
        b_rst = 1'b1;
        step();
        b_rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        b_rst = 1'b1;
        step();
        b_rst = 1'b0;
        b_clear_window("b_rst_mid_clear");
        b_rd(0, 5'd23, 32'd0);
        b_rd(1, 5'd30, 32'd0);
        b_rd(2, 5'd0, 32'd0);
        step();

        step();
        step();
        chk("a_queue_drained", qa.size(), 32'd0);
        chk("b_queue_drained", qb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
